// File: rtl/id_ex_cnt_reg.sv
// ----------------------------------------------------------------------------
// id_ex_cnt_reg
//   Decodes an RV32I instruction held in IF/ID into the compact EX-stage
//   control bundle and registers it as the ID/EX pipeline stage. The hazard
//   unit drives stall (hold) and flush (bubble insertion).
//
// Parameters
//   XLEN        instruction width (only 32 supported)
//   NOP_ILLEGAL 1: illegal opcode becomes a bubble; 0: passes with valid=1
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   instr, id_valid       instruction from IF/ID and its valid flag
//   stall, flush          hold / bubble controls (flush wins over stall)
//   ex_valid              EX-stage instruction is real
//   ex_ex                 [2] op B = imm, [1:0] ALU op class
//   ex_jump_t             00 none, 01 JAL, 10 JALR, 11 BRANCH
//   ex_slt, ex_lui        compare / immediate result selects
//   ex_funct3, ex_funct7b5 forwarded instruction fields
//   ex_mem_write, ex_mem_read, ex_reg_write, ex_result_src
//   ex_illegal            opcode outside the supported set
// ----------------------------------------------------------------------------
module id_ex_cnt_reg #(
    parameter int XLEN        = 32,
    parameter bit NOP_ILLEGAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr,
    input  logic            id_valid,
    input  logic            stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic [2:0]      ex_ex,
    output logic [1:0]      ex_jump_t,
    output logic            ex_slt,
    output logic            ex_lui,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_mem_write,
    output logic            ex_mem_read,
    output logic            ex_reg_write,
    output logic [1:0]      ex_result_src,
    output logic            ex_illegal
);

    typedef struct packed {
        logic       valid;
        logic [2:0] ex;
        logic [1:0] jump_t;
        logic       slt;
        logic       lui;
        logic [2:0] funct3;
        logic       funct7b5;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
        logic [1:0] result_src;
        logic       illegal;
    } ctrl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    ctrl_t dec;      // raw decode of instr
    ctrl_t bund_d;   // next-state bundle after valid gating
    ctrl_t bund_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_slt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign is_slt = (funct3 == 3'b010) || (funct3 == 3'b011);

    always_comb begin
        dec          = '0;
        dec.funct3   = funct3;
        dec.funct7b5 = instr[30];
        unique case (opcode)
            OP_R: begin
                dec.ex        = 3'b010;
                dec.reg_write = 1'b1;
                dec.slt       = is_slt;
            end
            OP_I: begin
                dec.ex        = 3'b111;
                dec.reg_write = 1'b1;
                dec.slt       = is_slt;
            end
            OP_LOAD: begin
                dec.ex         = 3'b100;
                dec.mem_read   = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b01;
            end
            OP_STORE: begin
                dec.ex        = 3'b100;
                dec.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                dec.ex     = 3'b001;
                dec.jump_t = 2'b11;
            end
            OP_JAL: begin
                dec.jump_t     = 2'b01;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
            end
            OP_JALR: begin
                dec.ex         = 3'b100;
                dec.jump_t     = 2'b10;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
            end
            OP_LUI: begin
                dec.ex        = 3'b100;
                dec.lui       = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: begin
                // Unknown opcode: every control, including forwarded fields, is 0.
                dec          = '0;
                dec.illegal  = 1'b1;
            end
        endcase
    end

    // A non-valid slot keeps only the illegal flag so a bubble can never
    // write registers or memory, yet the trap logic still sees the cause.
    always_comb begin
        bund_d         = dec;
        bund_d.valid   = id_valid & ~(dec.illegal & NOP_ILLEGAL);
        bund_d.illegal = dec.illegal & id_valid;
        if (!bund_d.valid) begin
            bund_d         = '0;
            bund_d.illegal = dec.illegal & id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)        bund_q <= '0;
        else if (flush) bund_q <= '0;
        else if (!stall) bund_q <= bund_d;
    end

    assign ex_valid      = bund_q.valid;
    assign ex_ex         = bund_q.ex;
    assign ex_jump_t     = bund_q.jump_t;
    assign ex_slt        = bund_q.slt;
    assign ex_lui        = bund_q.lui;
    assign ex_funct3     = bund_q.funct3;
    assign ex_funct7b5   = bund_q.funct7b5;
    assign ex_mem_write  = bund_q.mem_write;
    assign ex_mem_read   = bund_q.mem_read;
    assign ex_reg_write  = bund_q.reg_write;
    assign ex_result_src = bund_q.result_src;
    assign ex_illegal    = bund_q.illegal;

endmodule

// File: tb/tb_id_ex_cnt_reg.sv
module tb_id_ex_cnt_reg;

    logic        clk = 1'b0;
    logic        rst, id_valid, stall, flush;
    logic [31:0] instr;

    // dut0: NOP_ILLEGAL=1, dut1: NOP_ILLEGAL=0, same stimulus
    logic        v0, slt0, lui0, f7_0, mw0, mr0, rw0, ill0;
    logic [2:0]  ex0, f3_0;
    logic [1:0]  jt0, rs0;
    logic        v1, slt1, lui1, f7_1, mw1, mr1, rw1, ill1;
    logic [2:0]  ex1, f3_1;
    logic [1:0]  jt1, rs1;

    always #5 clk = ~clk;

    id_ex_cnt_reg #(.XLEN(32), .NOP_ILLEGAL(1'b1)) dut0 (
        .clk(clk), .rst(rst), .instr(instr), .id_valid(id_valid),
        .stall(stall), .flush(flush),
        .ex_valid(v0), .ex_ex(ex0), .ex_jump_t(jt0), .ex_slt(slt0),
        .ex_lui(lui0), .ex_funct3(f3_0), .ex_funct7b5(f7_0),
        .ex_mem_write(mw0), .ex_mem_read(mr0), .ex_reg_write(rw0),
        .ex_result_src(rs0), .ex_illegal(ill0)
    );

    id_ex_cnt_reg #(.XLEN(32), .NOP_ILLEGAL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .instr(instr), .id_valid(id_valid),
        .stall(stall), .flush(flush),
        .ex_valid(v1), .ex_ex(ex1), .ex_jump_t(jt1), .ex_slt(slt1),
        .ex_lui(lui1), .ex_funct3(f3_1), .ex_funct7b5(f7_1),
        .ex_mem_write(mw1), .ex_mem_read(mr1), .ex_reg_write(rw1),
        .ex_result_src(rs1), .ex_illegal(ill1)
    );

    // 18-bit view: valid,ex[3],jt[2],slt,lui,f3[3],f7b5,mw,mr,rw,rs[2],ill
    logic [17:0] obs0, obs1;
    assign obs0 = {v0, ex0, jt0, slt0, lui0, f3_0, f7_0, mw0, mr0, rw0, rs0, ill0};
    assign obs1 = {v1, ex1, jt1, slt1, lui1, f3_1, f7_1, mw1, mr1, rw1, rs1, ill1};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] mk(
        input logic v, input logic [2:0] ex, input logic [1:0] jt,
        input logic slt, input logic lui, input logic [2:0] f3, input logic f7,
        input logic mw, input logic mr, input logic rw, input logic [1:0] rs,
        input logic ill);
        return {v, ex, jt, slt, lui, f3, f7, mw, mr, rw, rs, ill};
    endfunction

    // Drive new inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic [31:0] i, input logic vld,
                        input logic s, input logic f, input logic r);
        instr = i; id_valid = vld; stall = s; flush = f; rst = r;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADDI = 32'h00A00093;
    localparam logic [31:0] SLT  = 32'h0020A1B3;
    localparam logic [31:0] SUB  = 32'h40208133;
    localparam logic [31:0] JAL  = 32'h008000EF;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] JALR = 32'h000080E7;
    localparam logic [31:0] LUI  = 32'h123452B7;
    localparam logic [31:0] LW   = 32'h0000A103;
    localparam logic [31:0] SW   = 32'h0020A023;
    localparam logic [31:0] BAD  = 32'hFFFFFFFF;

    logic [17:0] e_addi;

    initial begin
        e_addi = mk(1, 3'b111, 2'b00, 0, 0, 3'b000, 0, 0, 0, 1, 2'b00, 0);

        // Reset held 2 cycles with a live instruction in IF/ID
        step(ADDI, 1, 0, 0, 1);
        chk("reset_c1", obs0, 18'h0);
        step(ADDI, 1, 0, 0, 1);
        chk("reset_c2", obs0, 18'h0);
        chk("reset_c2_d1", obs1, 18'h0);

        // First decoded bundle one edge after rst falls
        step(ADDI, 1, 0, 0, 0);
        chk("addi", obs0, e_addi);
        step(SLT, 1, 0, 0, 0);
        chk("slt", obs0, mk(1, 3'b010, 2'b00, 1, 0, 3'b010, 0, 0, 0, 1, 2'b00, 0));
        step(SUB, 1, 0, 0, 0);
        chk("sub_f7b5", obs0, mk(1, 3'b010, 2'b00, 0, 0, 3'b000, 1, 0, 0, 1, 2'b00, 0));
        step(JAL, 1, 0, 0, 0);
        chk("jal", obs0, mk(1, 3'b000, 2'b01, 0, 0, 3'b000, 0, 0, 0, 1, 2'b10, 0));
        step(BEQ, 1, 0, 0, 0);
        chk("beq", obs0, mk(1, 3'b001, 2'b11, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00, 0));
        step(JALR, 1, 0, 0, 0);
        chk("jalr", obs0, mk(1, 3'b100, 2'b10, 0, 0, 3'b000, 0, 0, 0, 1, 2'b10, 0));
        step(LUI, 1, 0, 0, 0);
        chk("lui", obs0, mk(1, 3'b100, 2'b00, 0, 1, 3'b101, 0, 0, 0, 1, 2'b00, 0));
        step(LW, 1, 0, 0, 0);
        chk("lw", obs0, mk(1, 3'b100, 2'b00, 0, 0, 3'b010, 0, 0, 1, 1, 2'b01, 0));
        chk("lw_d1", obs1, mk(1, 3'b100, 2'b00, 0, 0, 3'b010, 0, 0, 1, 1, 2'b01, 0));
        step(SW, 1, 0, 0, 0);
        chk("sw", obs0, mk(1, 3'b100, 2'b00, 0, 0, 3'b010, 0, 1, 0, 0, 2'b00, 0));

        // id_valid=0 loads a bubble
        step(ADDI, 0, 0, 0, 0);
        chk("idvalid0", obs0, 18'h0);

        // Stall holds addi for 3 cycles while IF/ID shows beq
        step(ADDI, 1, 0, 0, 0);
        chk("stall_load", obs0, e_addi);
        for (int k = 0; k < 3; k++) begin
            step(BEQ, 1, 1, 0, 0);
            chk($sformatf("stall_hold%0d", k), obs0, e_addi);
        end
        // Flush overrides stall
        step(BEQ, 1, 1, 1, 0);
        chk("stall_flush", obs0, 18'h0);
        chk("stall_flush_d1", obs1, 18'h0);

        // Release: stalled-over beq now loads
        step(BEQ, 1, 0, 0, 0);
        chk("post_flush_beq", obs0, mk(1, 3'b001, 2'b11, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00, 0));

        // Reset during stall takes effect at that edge
        step(ADDI, 1, 0, 0, 0);
        step(ADDI, 1, 1, 0, 1);
        chk("rst_in_stall", obs0, 18'h0);

        // Illegal opcode: bubble on dut0, passes on dut1
        step(BAD, 1, 0, 0, 0);
        chk("illegal_nop1", obs0, mk(0, 3'b000, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00, 1));
        chk("illegal_nop0", obs1, mk(1, 3'b000, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00, 1));

        // Illegal with id_valid=0: illegal flag gated off
        step(BAD, 0, 0, 0, 0);
        chk("illegal_novld0", obs0, 18'h0);
        chk("illegal_novld1", obs1, 18'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_cnt_reg.md
Name: id_ex_cnt_reg

Overview:
- Decode-side producer of the EX-stage control bundle: decodes a 32-bit RV32I instruction from the IF/ID register into the compact control word the EX-stage control logic consumes.
- Fields driven: ex, jump_t, slt, lui, plus the memory and writeback controls.
- Registers that bundle into the ID/EX pipeline stage, with stall (hold) and flush (bubble insertion).
- Sits between IF/ID and EX, driven by the hazard unit.

Parameters:
- XLEN, 32, instruction width; only 32 is supported.
- NOP_ILLEGAL, 1, when 1 an illegal opcode is converted to a bubble (valid=0); when 0 it passes with valid=1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- instr  input  XLEN  instruction from IF/ID
- id_valid  input  1  instr holds a real instruction
- stall  input  1  hold the ID/EX contents
- flush  input  1  load a bubble into ID/EX
- ex_valid  output  1  EX-stage instruction is real
- ex_ex  output  3  [2]=ALU operand B is the immediate; [1:0]=ALU op class: 00 add, 01 sub/compare, 10 R-type funct, 11 I-type funct
- ex_jump_t  output  2  00 none, 01 JAL, 10 JALR, 11 BRANCH
- ex_slt  output  1  slt/sltu/slti/sltiu; selects the compare result
- ex_lui  output  1  LUI; selects the immediate result
- ex_funct3  output  3  funct3 field, forwarded for branch condition and ALU
- ex_funct7b5  output  1  instr[30], forwarded
- ex_mem_write  output  1  store
- ex_mem_read  output  1  load
- ex_reg_write  output  1  writes rd
- ex_result_src  output  2  00 ALU, 01 memory, 10 PC+4
- ex_illegal  output  1  opcode not in the supported set

Behaviour:
Decode is combinational from instr[6:0], [14:12] and [30]. Registers load on the next clk edge, so latency is 1 cycle.

Opcode table (unlisted fields are 0):
- 0110011 R: ex=010, reg_write=1, slt=(funct3==010 or 011)
- 0010011 I-ALU: ex=111, reg_write=1, slt=(funct3==010 or 011)
- 0000011 LOAD: ex=100, mem_read=1, reg_write=1, result_src=01
- 0100011 STORE: ex=100, mem_write=1
- 1100011 BRANCH: ex=001, jump_t=11
- 1101111 JAL: jump_t=01, reg_write=1, result_src=10
- 1100111 JALR: ex=100, jump_t=10, reg_write=1, result_src=10
- 0110111 LUI: ex=100, lui=1, reg_write=1
- Any other opcode: illegal=1, all other controls 0.

Register update, in priority order:
1. rst=1: every output register is 0. This is the bubble state: valid=0, all controls 0.
2. flush=1: load the bubble (all outputs 0). Flush overrides stall.
3. stall=1: every register holds its value.
4. Otherwise, load the decoded bundle with:
   - ex_valid = id_valid & ~(illegal & NOP_ILLEGAL).
   - If ex_valid=0, every control output except ex_illegal is forced to 0, so a bubble never writes registers or memory.
   - ex_illegal is registered as decoded, gated only by id_valid.

Further rules:
- id_valid=0 with stall=0 loads a bubble.
- The bubble encoding is all-zero, so the EX control logic sees ex=000 (add), jump_t=00, lui=slt=0.
- rst asserted mid-stall or mid-flush takes effect at the same edge.
- Outputs are registered only; nothing combinational reaches the EX stage.
- slt and lui are never both 1. jump_t=11 implies reg_write=0.

Test Plan:
- Reset: rst=1 for 2 cycles, then any instr -> all outputs 0 during reset; first decoded bundle appears one edge after rst falls.
- ALU decode: 0x00A00093 (addi x1,x0,10) -> ex=111, reg_write=1, slt=0. Next, 0x0020A1B3 (slt x3,x1,x2) -> ex=010, slt=1, funct3=010, reg_write=1.
- Jump/branch: 0x008000EF (jal) -> jump_t=01, result_src=10, reg_write=1. 0x00208463 (beq) -> jump_t=11, ex=001, reg_write=0. 0x000080E7 (jalr) -> jump_t=10, ex=100.
- LUI/mem: 0x123452B7 (lui) -> lui=1, ex=100. 0x0000A103 (lw) -> mem_read=1, result_src=01. 0x0020A023 (sw) -> mem_write=1, reg_write=0.
- Stall/flush: load addi, then hold stall=1 for 3 cycles while instr changes to beq -> outputs stay at addi values. Assert stall=1 and flush=1 together -> bubble on the next edge.
- Illegal: instr=0xFFFFFFFF, id_valid=1, NOP_ILLEGAL=1 -> ex_valid=0, ex_illegal=1, reg_write=mem_write=0. With NOP_ILLEGAL=0 -> ex_valid=1, ex_illegal=1, all other controls 0.
